// File: rtl/snake_pkg.sv
// Shared snake playfield definitions: coordinate widths, bounds, reset food spot,
// LFSR constants, food FSM states and the candidate-position mapping.
package snake_pkg;

    localparam int X_W = 5;
    localparam int Y_W = 4;

    localparam logic [X_W-1:0] X_MIN = 5'd1;
    localparam logic [X_W-1:0] X_MAX = 5'd20;
    localparam logic [Y_W-1:0] Y_MIN = 4'd1;
    localparam logic [Y_W-1:0] Y_MAX = 4'd15;

    localparam logic [X_W-1:0] FOOD_RST_X = 5'd10;
    localparam logic [Y_W-1:0] FOOD_RST_Y = 4'd10;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as a mask over bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        PLACED    = 2'd0,
        WAIT_SCAN = 2'd1,
        SCAN      = 2'd2
    } food_state_t;

    // Values 20..31 fold down onto 9..20 so every candidate lands in 1..20.
    function automatic logic [X_W-1:0] cand_x(input logic [4:0] l_lo);
        cand_x = (l_lo < X_MAX) ? l_lo + 5'd1 : l_lo - 5'd11;
    endfunction

    function automatic logic [Y_W-1:0] cand_y(input logic [3:0] l_mid);
        cand_y = (l_mid != 4'd0) ? l_mid : Y_MIN;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the food placement random source.
module lfsr16
    import snake_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/food_unit.sv
// Snake food placement: detects the head eating the food, then rescans the streamed
// body until a random candidate is collision-free. Optional FOOD_SCORE_EN adds o_score.
module food_unit
    import snake_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [X_W-1:0] i_pos_x,
    input  logic [Y_W-1:0] i_pos_y,
    input  logic           i_pos_first,
    input  logic           i_pos_last,
    input  logic           i_pos_valid,
    output logic           o_eat,
    output logic [X_W-1:0] o_food_x,
    output logic [Y_W-1:0] o_food_y,
    output logic           o_food_valid
`ifdef FOOD_SCORE_EN
    ,
    output logic [7:0]     o_score
`endif
);

    food_state_t    state, state_nxt;
    logic [15:0]    lfsr;
    logic           lfsr_unused;
    logic [X_W-1:0] cand_x_q, food_x_nxt;
    logic [Y_W-1:0] cand_y_q, food_y_nxt;
    logic           coll, coll_nxt;
    logic           eat_nxt, food_valid_nxt;
    logic           load_cand, scan_end;
    logic           head, hit_food, hit_cand;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr)
    );

    assign lfsr_unused = ^{lfsr[15:12], lfsr[7:5]};

    assign head     = i_pos_valid & i_pos_first;
    assign hit_food = (i_pos_x == o_food_x) && (i_pos_y == o_food_y);
    assign hit_cand = i_pos_valid && (i_pos_x == cand_x_q) && (i_pos_y == cand_y_q);

    always_comb begin
        state_nxt      = state;
        coll_nxt       = coll;
        eat_nxt        = 1'b0;
        food_x_nxt     = o_food_x;
        food_y_nxt     = o_food_y;
        food_valid_nxt = o_food_valid;
        load_cand      = 1'b0;
        scan_end       = 1'b0;

        case (state)
            PLACED: begin
                if (head && hit_food) begin
                    eat_nxt        = 1'b1;
                    food_valid_nxt = 1'b0;
                    load_cand      = 1'b1;
                    state_nxt      = WAIT_SCAN;
                end
            end
            WAIT_SCAN: begin
                // The head sample opens the scan and is itself compared.
                if (head) begin
                    coll_nxt  = hit_cand;
                    state_nxt = SCAN;
                    scan_end  = i_pos_last;
                end
            end
            SCAN: begin
                if (!i_pos_valid) begin
                    state_nxt = WAIT_SCAN;
                end else begin
                    coll_nxt = coll | hit_cand;
                    scan_end = i_pos_last;
                end
            end
            default: state_nxt = PLACED;
        endcase

        if (scan_end) begin
            if (coll_nxt) begin
                load_cand = 1'b1;
                state_nxt = WAIT_SCAN;
            end else begin
                food_x_nxt     = cand_x_q;
                food_y_nxt     = cand_y_q;
                food_valid_nxt = 1'b1;
                state_nxt      = PLACED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= PLACED;
            coll         <= 1'b0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            o_eat        <= 1'b0;
            o_food_x     <= FOOD_RST_X;
            o_food_y     <= FOOD_RST_Y;
            o_food_valid <= 1'b1;
        end else begin
            state        <= state_nxt;
            coll         <= coll_nxt;
            o_eat        <= eat_nxt;
            o_food_x     <= food_x_nxt;
            o_food_y     <= food_y_nxt;
            o_food_valid <= food_valid_nxt;
            if (load_cand) begin
                cand_x_q <= cand_x(lfsr[4:0]);
                cand_y_q <= cand_y(lfsr[11:8]);
            end
        end
    end

`ifdef FOOD_SCORE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_score <= 8'd0;
        end else if (o_eat && (o_score != 8'hFF)) begin
            o_score <= o_score + 8'd1;
        end
    end
`endif

endmodule

// File: doc/food_unit.md
FOOD_UNIT -- requirements
Module: food_unit

Interface
REQ-001 clk  input  1  single system clock; all state on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 i_pos_x  input  5  streamed snake segment x.
REQ-004 i_pos_y  input  4  streamed snake segment y.
REQ-005 i_pos_first  input  1  current sample is the head (segment 0).
REQ-006 i_pos_last  input  1  current sample is the tail segment.
REQ-007 i_pos_valid  input  1  current sample is a live segment.
REQ-008 o_eat  output  1  one-cycle pulse: head entered food cell.
REQ-009 o_food_x  output  5  food x.
REQ-010 o_food_y  output  4  food y.
REQ-011 o_food_valid  output  1  food placed and displayable.

Function
REQ-012 Playfield SHALL be x 1..20, y 1..15; food SHALL never be placed outside it.
REQ-013 A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) SHALL advance every clock while out of reset and never reach all-zero.
REQ-014 Candidate x SHALL be L[4:0]+1 when L[4:0]<20, else L[4:0]-11; candidate y SHALL be L[11:8] when nonzero, else 1.
REQ-015 States SHALL be PLACED, WAIT_SCAN, SCAN; reset state PLACED.
REQ-016 PLACED: a sample with i_pos_valid & i_pos_first & (i_pos_x,i_pos_y)==food SHALL assert o_eat on the next cycle for exactly one cycle, clear o_food_valid on that same cycle, latch a candidate, enter WAIT_SCAN.
REQ-017 WAIT_SCAN: on the next sample with i_pos_valid & i_pos_first SHALL clear the collision flag, include that sample in the compare, enter SCAN.
REQ-018 SCAN: every sample with i_pos_valid whose position equals the candidate SHALL set the collision flag.
REQ-019 SCAN: on the sample with i_pos_valid & i_pos_last, including that sample's compare: no collision -> food := candidate, o_food_valid=1, PLACED; collision -> latch new candidate, WAIT_SCAN.
REQ-020 A sample with both i_pos_first and i_pos_last (length 0) SHALL be handled as start and end of the same scan.
REQ-021 In SCAN, i_pos_valid falling without i_pos_last SHALL abort the scan to WAIT_SCAN, keeping the candidate.
REQ-022 o_eat SHALL never assert outside PLACED and SHALL never assert on consecutive cycles.
REQ-023 Samples with i_pos_valid=0 SHALL be ignored in every state.

Reset
REQ-024 Reset SHALL set o_eat=0, o_food_x=10, o_food_y=10, o_food_valid=1, state PLACED, LFSR=seed, collision=0.
REQ-025 Reset asserted mid-SCAN SHALL discard candidate and flag immediately, without waiting for a clock edge.

Configuration
REQ-026 Macro FOOD_SCORE_EN defined: output o_score (8 bits) SHALL reset to 0, increment on every o_eat cycle, saturate at 255.
REQ-027 FOOD_SCORE_EN undefined: port o_score and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package snake_pkg SHALL hold coordinate widths, playfield bounds (X 1..20, Y 1..15), reset food position, LFSR seed and taps, and the state enum typedef.
REQ-029 The LFSR SHALL be a sub-module lfsr16 (clk, rst_n, state output); all other logic in food_unit.

Verification
REQ-030 Reset then stream head (10,10) first+valid -> o_eat=1 exactly one cycle later, o_food_valid=0 that cycle.
REQ-031 Force LFSR candidate (5,5), stream body containing (5,5) -> no placement, new candidate, rescan; next clean scan -> o_food_valid=1 at candidate.
REQ-032 Stream of 4 segments with no match, candidate (7,3) -> food=(7,3) the cycle after the i_pos_last sample.
REQ-033 Head held on food for 3 consecutive frames -> single o_eat pulse only.
REQ-034 rst_n low during SCAN -> outputs return to REQ-024 values asynchronously.
REQ-035 10000 random placements -> every food in x 1..20, y 1..15; FOOD_SCORE_EN build: 300 eats -> o_score=255.
